// File: rtl/sar_scan_sequencer.sv
// Multi-channel SAR scan sequencer: walks the enabled channels, runs a binary-search
// conversion per sample against the external comparator, averages and hands out tagged results.
module sar_scan_sequencer #(
  parameter int NUM_BITS      = 4,
  parameter int NUM_CH        = 4,
  parameter int OSR_LOG2_MAX  = 3,
  parameter int SETTLE_CYCLES = 1,
  parameter int CMP_LAT       = 1,
  localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int OSR_W        = (OSR_LOG2_MAX > 0) ? $clog2(OSR_LOG2_MAX + 1) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic                continuous_i,
  input  logic                abort_i,
  input  logic [NUM_CH-1:0]   chMask_i,
  input  logic [OSR_W-1:0]    osrLog2_i,
  input  logic                cmpOut_i,
  output logic [CH_W-1:0]     chSel_o,
  output logic                sampleSig_o,
  output logic [NUM_BITS-1:0] dacCode_o,
  output logic                busy_o,
  output logic [NUM_BITS-1:0] resData_o,
  output logic [CH_W-1:0]     resCh_o,
  output logic                resValid_o,
  input  logic                resReady_i
);

  localparam int ACC_W = NUM_BITS + OSR_LOG2_MAX;
  localparam int CNT_W = OSR_LOG2_MAX + 1;
  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam int LAT_W = (CMP_LAT > 0) ? $clog2(CMP_LAT + 1) : 1;
  localparam int BIT_W = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;

  typedef enum logic [2:0] {IDLE, SELECT, SAMPLE, CONVERT, ACCUM, OUTPUT} state_t;

  state_t              state_q;
  logic [CH_W-1:0]     chSel_q;
  logic [NUM_CH-1:0]   mask_q;
  logic                cont_q;
  logic [OSR_W-1:0]    osr_q;
  logic [SET_W-1:0]    settle_q;
  logic [LAT_W-1:0]    lat_q;
  logic [BIT_W-1:0]    bit_q;
  logic [NUM_BITS-1:0] dac_q;
  logic                sample_q;
  logic [ACC_W-1:0]    acc_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [NUM_BITS-1:0] resData_q;
  logic [CH_W-1:0]     resCh_q;
  logic                resValid_q;

  logic [NUM_BITS-1:0] trialBit;
  logic [NUM_BITS-1:0] keptCode_d;
  logic [ACC_W-1:0]    accSum_d;
  logic [ACC_W-1:0]    accPick;
  logic [NUM_BITS-1:0] resLoad_d;
  logic [CNT_W-1:0]    cntNext_d;
  logic [CNT_W-1:0]    cntTarget;
  logic                lastSample;
  logic                resFree;
  logic                hasNext;
  logic [CH_W-1:0]     nextCh;
  logic [CH_W-1:0]     firstCh;
  logic [CH_W-1:0]     startCh;
  logic [CH_W-1:0]     advCh;
  state_t              advState;
  logic [OSR_W-1:0]    osrClamp;

  function automatic logic [CH_W-1:0] lowestCh(input logic [NUM_CH-1:0] m);
    logic [CH_W-1:0] r;
    r = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (m[i]) r = CH_W'(i);
    end
    return r;
  endfunction

  always_comb begin
    trialBit   = NUM_BITS'(1) << bit_q;
    keptCode_d = cmpOut_i ? dac_q : (dac_q & ~trialBit);
    accSum_d   = acc_q + ACC_W'(dac_q);
    accPick    = (state_q == ACCUM) ? accSum_d : acc_q;
    resLoad_d  = NUM_BITS'(accPick >> osr_q);
    cntNext_d  = cnt_q + CNT_W'(1);
    cntTarget  = CNT_W'(1) << osr_q;
    lastSample = (cntNext_d >= cntTarget);
    resFree    = !resValid_q || resReady_i;
    firstCh    = lowestCh(mask_q);
    startCh    = lowestCh(chMask_i);
    osrClamp   = (int'(osrLog2_i) > OSR_LOG2_MAX) ? OSR_W'(OSR_LOG2_MAX) : osrLog2_i;
    nextCh     = '0;
    hasNext    = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask_q[i] && (i > int'(chSel_q))) begin
        nextCh  = CH_W'(i);
        hasNext = 1'b1;
      end
    end
    if (hasNext) begin
      advCh    = nextCh;
      advState = SELECT;
    end else if (cont_q) begin
      advCh    = firstCh;
      advState = SELECT;
    end else begin
      advCh    = chSel_q;
      advState = IDLE;
    end
  end

  // The final accumulation loads the result register directly when it is free,
  // so OUTPUT is only occupied while the consumer is back-pressuring.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      chSel_q    <= '0;
      mask_q     <= '0;
      cont_q     <= 1'b0;
      osr_q      <= '0;
      settle_q   <= '0;
      lat_q      <= '0;
      bit_q      <= '0;
      dac_q      <= '0;
      sample_q   <= 1'b0;
      acc_q      <= '0;
      cnt_q      <= '0;
      resData_q  <= '0;
      resCh_q    <= '0;
      resValid_q <= 1'b0;
    end else begin
      if (resValid_q && resReady_i) resValid_q <= 1'b0;
      if (abort_i) begin
        state_q  <= IDLE;
        dac_q    <= '0;
        sample_q <= 1'b0;
        acc_q    <= '0;
        cnt_q    <= '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (start_i && (|chMask_i)) begin
              mask_q   <= chMask_i;
              cont_q   <= continuous_i;
              osr_q    <= osrClamp;
              chSel_q  <= startCh;
              settle_q <= '0;
              acc_q    <= '0;
              cnt_q    <= '0;
              state_q  <= SELECT;
            end
          end
          SELECT: begin
            if (settle_q == SET_W'(SETTLE_CYCLES - 1)) begin
              state_q  <= SAMPLE;
              sample_q <= 1'b1;
              dac_q    <= '0;
            end else begin
              settle_q <= settle_q + SET_W'(1);
            end
          end
          SAMPLE: begin
            sample_q <= 1'b0;
            dac_q    <= NUM_BITS'(1) << (NUM_BITS - 1);
            bit_q    <= BIT_W'(NUM_BITS - 1);
            lat_q    <= '0;
            state_q  <= CONVERT;
          end
          CONVERT: begin
            if (lat_q == LAT_W'(CMP_LAT)) begin
              lat_q <= '0;
              if (bit_q == '0) begin
                dac_q   <= keptCode_d;
                state_q <= ACCUM;
              end else begin
                dac_q <= keptCode_d | (trialBit >> 1);
                bit_q <= bit_q - BIT_W'(1);
              end
            end else begin
              lat_q <= lat_q + LAT_W'(1);
            end
          end
          ACCUM: begin
            if (!lastSample) begin
              acc_q    <= accSum_d;
              cnt_q    <= cntNext_d;
              sample_q <= 1'b1;
              dac_q    <= '0;
              state_q  <= SAMPLE;
            end else begin
              cnt_q <= '0;
              if (resFree) begin
                resData_q  <= resLoad_d;
                resCh_q    <= chSel_q;
                resValid_q <= 1'b1;
                acc_q      <= '0;
                chSel_q    <= advCh;
                settle_q   <= '0;
                state_q    <= advState;
              end else begin
                acc_q   <= accSum_d;
                state_q <= OUTPUT;
              end
            end
          end
          OUTPUT: begin
            if (resFree) begin
              resData_q  <= resLoad_d;
              resCh_q    <= chSel_q;
              resValid_q <= 1'b1;
              acc_q      <= '0;
              chSel_q    <= advCh;
              settle_q   <= '0;
              state_q    <= advState;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign chSel_o     = chSel_q;
  assign sampleSig_o = sample_q;
  assign dacCode_o   = dac_q;
  assign busy_o      = (state_q != IDLE);
  assign resData_o   = resData_q;
  assign resCh_o     = resCh_q;
  assign resValid_o  = resValid_q;

endmodule

// File: tb/tb_sar_scan_sequencer.sv
// Bench for sar_scan_sequencer: an analog stand-in (mux, S/H, delayed comparator) plus a
// scan/average reference model that predicts every tagged result.
module tb_sar_scan_sequencer;

  localparam int NB     = 4;
  localparam int NCH    = 4;
  localparam int OSRMAX = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic           start, continuous, abort, resReady;
  logic [NCH-1:0] chMask;
  logic [1:0]     osrLog2;
  logic           cmpOut;
  logic [1:0]     chSel;
  logic           sampleSig;
  logic [NB-1:0]  dacCode;
  logic           busy;
  logic [NB-1:0]  resData;
  logic [1:0]     resCh;
  logic           resValid;

  int checks = 0;
  int errors = 0;

  int vinTab [NCH][4];
  int envIdx [NCH];
  int mIdx [NCH];
  int heldVin = 0;
  logic [NB-1:0] dacDly = '0;

  int expCh[$];
  int expData[$];
  bit mActive = 0;
  bit mCont = 0;
  int mOsr = 0;
  logic [NCH-1:0] mMask = '0;
  int mCh = 0, mSum = 0, mCnt = 0, mNext = 0;

  int clearReq = 0, clearAck = 0, startReq = 0, startAck = 0;
  logic [NCH-1:0] reqMask = '0;
  int reqOsr = 0;
  bit reqCont = 0;

  sar_scan_sequencer dut (
    .clk(clk), .rst(rst), .start_i(start), .continuous_i(continuous), .abort_i(abort),
    .chMask_i(chMask), .osrLog2_i(osrLog2), .cmpOut_i(cmpOut), .chSel_o(chSel),
    .sampleSig_o(sampleSig), .dacCode_o(dacCode), .busy_o(busy), .resData_o(resData),
    .resCh_o(resCh), .resValid_o(resValid), .resReady_i(resReady)
  );

  always #5 clk = ~clk;

  // Comparator sees the DAC one cycle late, so sampling a bit too early gets a stale trial.
  always @(posedge clk) dacDly <= dacCode;
  assign cmpOut = (heldVin >= int'(dacDly));

  function automatic int nextEnabled(input logic [NCH-1:0] m, input int ch);
    for (int i = ch + 1; i < NCH; i++) if (m[i]) return i;
    return -1;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  always @(negedge clk) begin
    if (clearReq != clearAck) begin
      clearAck = clearReq;
      expCh.delete();
      expData.delete();
      mActive = 0; mSum = 0; mCnt = 0;
      for (int c = 0; c < NCH; c++) begin envIdx[c] = 0; mIdx[c] = 0; end
    end
    if (startReq != startAck) begin
      startAck = startReq;
      mActive = 1; mMask = reqMask; mOsr = reqOsr; mCont = reqCont;
      mCh = nextEnabled(reqMask, -1); mSum = 0; mCnt = 0;
    end
    if (!rst) begin
      if (resValid) begin
        checkOutput("result_expected", 32'(expCh.size() > 0), 1);
        if (expCh.size() > 0) begin
          checkOutput("res_data", 32'(resData), expData[0]);
          checkOutput("res_ch", 32'(resCh), expCh[0]);
          if (resReady) begin
            void'(expCh.pop_front());
            void'(expData.pop_front());
          end
        end
      end
      if (sampleSig) begin
        heldVin = vinTab[chSel][envIdx[chSel] % 4];
        envIdx[chSel] = envIdx[chSel] + 1;
        if (mActive) begin
          mSum += vinTab[mCh][mIdx[mCh] % 4];
          mIdx[mCh] = mIdx[mCh] + 1;
          mCnt++;
          if (mCnt == (1 << mOsr)) begin
            expCh.push_back(mCh);
            expData.push_back(mSum >> mOsr);
            mSum = 0; mCnt = 0;
            mNext = nextEnabled(mMask, mCh);
            if (mNext >= 0) mCh = mNext;
            else if (mCont) mCh = nextEnabled(mMask, -1);
            else mActive = 0;
          end
        end
      end
      if (abort) begin
        while (expCh.size() > ((resValid && !resReady) ? 1 : 0)) begin
          void'(expCh.pop_back());
          void'(expData.pop_back());
        end
        mActive = 0; mSum = 0; mCnt = 0;
        for (int c = 0; c < NCH; c++) mIdx[c] = envIdx[c];
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [NCH-1:0] m, input int osr, input bit cont, input bit accept);
    if (accept) begin
      reqMask = m;
      reqOsr = (osr > OSRMAX) ? OSRMAX : osr;
      reqCont = cont;
      startReq++;
    end
    chMask = m;
    osrLog2 = 2'(osr);
    continuous = cont;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic waitValid(input string tag, input int bound);
    int n = 0;
    while (!resValid && n < bound) begin tick(1); n++; end
    checkOutput({tag, "_valid"}, 32'(resValid), 1);
  endtask

  task automatic waitDone(input string tag, input int bound, input bit randReady);
    int n = 0;
    while ((busy || expCh.size() != 0) && n < bound) begin
      if (randReady) resReady = 1'($urandom_range(0, 1));
      tick(1);
      n++;
    end
    resReady = 1'b1;
    tick(2);
    checkOutput({tag, "_idle"}, 32'(busy), 0);
    checkOutput({tag, "_drained"}, 32'(expCh.size()), 0);
  endtask

  task automatic setChannel(input int ch, input int a, input int b, input int c, input int d);
    vinTab[ch][0] = a; vinTab[ch][1] = b; vinTab[ch][2] = c; vinTab[ch][3] = d;
  endtask

  initial begin
    int r0, r1;
    rst = 1'b0; start = 1'b0; continuous = 1'b0; abort = 1'b0; resReady = 1'b0;
    chMask = '0; osrLog2 = '0;
    for (int c = 0; c < NCH; c++) setChannel(c, 0, 0, 0, 0);
    #1 rst = 1'b1;
    #1;
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_valid", 32'(resValid), 0);
    checkOutput("rst_dac", 32'(dacCode), 0);
    checkOutput("rst_chsel", 32'(chSel), 0);
    checkOutput("rst_sample", 32'(sampleSig), 0);
    tick(2);
    rst = 1'b0;
    clearReq++;
    tick(1);

    $display("[TB] single conversion, code 9 on channel 0");
    setChannel(0, 9, 9, 9, 9);
    applyStimulus(4'b0001, 0, 0, 1);
    for (int e = 1; e <= 11; e++) begin
      tick(1);
      if (e == 1) checkOutput("busy_after_start", 32'(busy), 1);
      if (e == 2) checkOutput("dac_bit3", 32'(dacCode), 8);
      if (e == 3) checkOutput("dac_bit3_hold", 32'(dacCode), 8);
      if (e == 4) checkOutput("dac_bit2", 32'(dacCode), 12);
      if (e == 6) checkOutput("dac_bit1", 32'(dacCode), 10);
      if (e == 8) checkOutput("dac_bit0", 32'(dacCode), 9);
      if (e == 10) checkOutput("valid_before_latency", 32'(resValid), 0);
    end
    checkOutput("valid_at_latency", 32'(resValid), 1);
    checkOutput("single_data", 32'(resData), 9);
    checkOutput("single_ch", 32'(resCh), 0);

    $display("[TB] asynchronous reset during conversion");
    applyStimulus(4'b0001, 0, 0, 1);
    tick(5);
    #3 rst = 1'b1;
    clearReq++;
    #1;
    checkOutput("midrst_busy", 32'(busy), 0);
    checkOutput("midrst_valid", 32'(resValid), 0);
    checkOutput("midrst_dac", 32'(dacCode), 0);
    checkOutput("midrst_data", 32'(resData), 0);
    tick(1);
    rst = 1'b0;
    resReady = 1'b1;
    tick(1);

    $display("[TB] scan order over channels 1 and 3");
    setChannel(1, 3, 3, 3, 3);
    setChannel(3, 15, 15, 15, 15);
    applyStimulus(4'b1010, 0, 0, 1);
    waitValid("scan_first", 40);
    checkOutput("scan_first_ch", 32'(resCh), 1);
    checkOutput("scan_first_data", 32'(resData), 3);
    tick(1);
    waitValid("scan_second", 40);
    checkOutput("scan_second_ch", 32'(resCh), 3);
    checkOutput("scan_second_data", 32'(resData), 15);
    checkOutput("scan_done_busy", 32'(busy), 0);
    tick(1);
    checkOutput("scan_valid_drop", 32'(resValid), 0);

    $display("[TB] continuous averaging on channel 2");
    setChannel(2, 6, 7, 7, 8);
    applyStimulus(4'b0100, 2, 1, 1);
    for (int k = 0; k < 2; k++) begin
      waitValid("avg", 100);
      checkOutput("avg_data", 32'(resData), 7);
      checkOutput("avg_ch", 32'(resCh), 2);
      tick(1);
    end
    checkOutput("avg_still_busy", 32'(busy), 1);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    checkOutput("avg_abort_busy", 32'(busy), 0);
    checkOutput("avg_abort_dac", 32'(dacCode), 0);
    tick(2);

    $display("[TB] back-pressure with two channels");
    r0 = int'($urandom_range(0, 15));
    r1 = int'($urandom_range(0, 15));
    setChannel(0, r0, r0, r0, r0);
    setChannel(1, r1, r1, r1, r1);
    resReady = 1'b0;
    applyStimulus(4'b0011, 0, 0, 1);
    waitValid("bp_first", 40);
    tick(30);
    checkOutput("bp_held_valid", 32'(resValid), 1);
    checkOutput("bp_held_data", 32'(resData), r0);
    checkOutput("bp_held_ch", 32'(resCh), 0);
    checkOutput("bp_stall_busy", 32'(busy), 1);
    resReady = 1'b1;
    tick(1);
    checkOutput("bp_second_valid", 32'(resValid), 1);
    checkOutput("bp_second_data", 32'(resData), r1);
    checkOutput("bp_second_ch", 32'(resCh), 1);
    checkOutput("bp_second_idle", 32'(busy), 0);
    tick(1);
    checkOutput("bp_valid_drop", 32'(resValid), 0);

    $display("[TB] abort mid-conversion and ignored starts");
    applyStimulus(4'b0001, 0, 0, 1);
    tick(4);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    checkOutput("abort_busy", 32'(busy), 0);
    checkOutput("abort_dac", 32'(dacCode), 0);
    checkOutput("abort_sample", 32'(sampleSig), 0);
    applyStimulus(4'b0000, 0, 0, 0);
    tick(2);
    checkOutput("empty_mask_busy", 32'(busy), 0);
    applyStimulus(4'b0011, 0, 0, 1);
    tick(3);
    applyStimulus(4'b0100, 0, 1, 0);
    waitDone("busy_start", 200, 0);

    $display("[TB] randomized scans");
    for (int it = 0; it < 8; it++) begin
      for (int c = 0; c < NCH; c++)
        for (int k = 0; k < 4; k++) vinTab[c][k] = int'($urandom_range(0, 15));
      applyStimulus(4'($urandom_range(1, 15)), int'($urandom_range(0, 3)), 0, 1);
      waitDone("rand", 3000, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sar_scan_sequencer.md
Name: sar_scan_sequencer

Overview:
- Parametrised multi-channel successor to the single-channel SAR control path.
- Scans an enabled set of analog channels and runs a binary-search SAR conversion per channel against the external comparator.
- Optionally oversamples and averages each channel, then presents tagged results on a valid/ready interface.
- Sits between the digital control layer and the RNM analog blocks: analog mux (ch_sel), sample-and-hold (sample_sig), DAC (dac_code) and comparator (cmp_out).

Parameters:
NUM_BITS, 4, conversion resolution
NUM_CH, 4, number of analog input channels (>=1)
OSR_LOG2_MAX, 3, maximum log2 oversampling ratio
SETTLE_CYCLES, 1, mux settling cycles after a channel change (>=1)
CMP_LAT, 1, cycles from a dac_code change to a valid cmp_out (>=0)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle request to begin a scan
continuous  in  1  restart the scan automatically after the last channel
abort  in  1  terminate the current scan
ch_mask  in  NUM_CH  channel enable mask, latched on accepted start
osr_log2  in  clog2(OSR_LOG2_MAX+1)  samples per result = 2^osr_log2, latched on accepted start
cmp_out  in  1  comparator result: 1 when V_in >= V_dac
ch_sel  out  max(1,clog2(NUM_CH))  analog mux select
sample_sig  out  1  sample-and-hold strobe
dac_code  out  NUM_BITS  DAC trial code
busy  out  1  scan in progress
res_data  out  NUM_BITS  averaged conversion result
res_ch  out  max(1,clog2(NUM_CH))  channel tag for res_data
res_valid  out  1  result available
res_ready  in  1  consumer accepts the result

Behaviour:
- Reset: all outputs 0; FSM in IDLE; accumulator and sample counter cleared.
- FSM states: IDLE, SELECT, SAMPLE, CONVERT, ACCUM, OUTPUT.
- IDLE:
  - start=1 with ch_mask!=0: latch ch_mask, continuous and osr_log2; ch_sel = lowest enabled channel; go to SELECT.
  - start with ch_mask==0: ignored.
  - start while busy: ignored.
- SELECT: held for SETTLE_CYCLES cycles, then SAMPLE.
- SAMPLE: exactly 1 cycle; sample_sig=1 only in this state.
- CONVERT:
  - Bits are resolved MSB to LSB; each bit takes 1+CMP_LAT cycles.
  - Bit k: dac_code = kept bits | (1<<k). cmp_out is sampled on the last cycle of the bit; the trial bit is kept if cmp_out=1, cleared otherwise.
  - After bit 0, go to ACCUM. dac_code holds the final code until the next SAMPLE, then returns to 0.
- ACCUM:
  - 1 cycle; acc += code. acc width is NUM_BITS+OSR_LOG2_MAX, so no overflow is possible.
  - If sample count < 2^osr_log2: return to SAMPLE; ch_sel is unchanged and there is no resettle.
  - Otherwise: go to OUTPUT.
- OUTPUT:
  - When res_valid==0 or res_ready==1: load res_data = acc >> osr_log2 (truncating), res_ch = ch_sel, set res_valid; clear acc.
  - Then advance ch_sel to the next higher enabled channel and go to SELECT.
  - After the highest enabled channel: if continuous, wrap to the lowest enabled channel and go to SELECT; else go to IDLE.
  - When res_valid==1 and res_ready==0: stall in OUTPUT. No result is ever dropped or overwritten.
- Result handshake: res_valid falls on the edge where res_valid && res_ready, unless a new result loads on that same edge (back-to-back is allowed). res_data and res_ch are stable while res_valid=1.
- busy = (state != IDLE).
- abort:
  - Takes priority over all other inputs.
  - Next edge: go to IDLE; dac_code=0, sample_sig=0; acc cleared.
  - The pending result register is untouched and its handshake completes normally.
- Single-channel mask: there is no channel change, but SELECT still runs once per result.
- osr_log2 > OSR_LOG2_MAX is clamped to OSR_LOG2_MAX.
- rst mid-scan: immediate return to reset values, including clearing res_valid.
- Latency for the first result (osr_log2=0): res_valid rises 2+SETTLE_CYCLES+NUM_BITS*(1+CMP_LAT) edges after the edge sampling start. With defaults this is 11.

Test Plan:
- Reset values: assert rst mid-CONVERT -> all outputs 0 asynchronously; busy=0; res_valid=0.
- Single conversion: defaults, ch_mask=0001, V_in code 9 -> dac_code sequence 8,12,10,9; res_data=9, res_ch=0; res_valid at edge 11 after start.
- Scan order: ch_mask=1010, codes ch1=3 and ch3=15, continuous=0, res_ready=1 -> results (ch1,3) then (ch3,15); then busy=0.
- Continuous wrap and averaging: ch_mask=0100, osr_log2=2, V_in codes 6,7,7,8, continuous=1 -> res_data=7, res_ch=2, repeating until abort.
- Back-pressure: res_ready=0 with 2 channels enabled -> first result held stable, FSM stalls in OUTPUT; raising res_ready -> second result loads on the next edge, nothing lost.
- Abort and ignored start: abort mid-CONVERT -> IDLE next edge, dac_code=0; start with ch_mask=0 -> busy stays 0.
